// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: round-robin between execute stage and debug port, with a
// debug burst lock, an execute anti-starvation timeout and read-data return routing.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_req,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_gnt,
    output logic              ex_rvalid,
    output logic [DATA_W-1:0] ex_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    typedef enum logic {ARB, LOCK} state_e;
    localparam logic OWN_EX  = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    state_e            state_q, state_d;
    logic              rr_last_q;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              rd_pend_q, rd_owner_q;
    logic [DATA_W-1:0] ex_rdata_q, dbg_rdata_q;
    logic              force_ex;

    // The starvation timeout overrides both the lock and the round-robin choice.
    always_comb begin
        force_ex = ex_req && (wait_cnt_q == 4'(MAX_WAIT));
        ex_gnt   = 1'b0;
        dbg_gnt  = 1'b0;
        if (force_ex) begin
            ex_gnt = 1'b1;
        end else if (state_q == LOCK) begin
            dbg_gnt = dbg_req;
        end else if (ex_req && dbg_req) begin
            ex_gnt  = (rr_last_q == OWN_DBG);
            dbg_gnt = (rr_last_q == OWN_EX);
        end else begin
            ex_gnt  = ex_req;
            dbg_gnt = dbg_req;
        end
    end

    always_comb begin
        mem_en    = ex_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ex_gnt) begin
            mem_we    = ex_we;
            mem_addr  = ex_addr;
            mem_wdata = ex_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign stall      = ex_req & ~ex_gnt;
    assign ex_rvalid  = rd_pend_q & (rd_owner_q == OWN_EX);
    assign dbg_rvalid = rd_pend_q & (rd_owner_q == OWN_DBG);
    assign ex_rdata   = ex_rvalid  ? mem_rdata : ex_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (dbg_gnt && dbg_lock) state_d = LOCK;
            LOCK:    if (!dbg_lock)           state_d = ARB;
            default: state_d = ARB;
        endcase
        if (!ex_req || ex_gnt)    wait_cnt_d = '0;
        else if (&wait_cnt_q)     wait_cnt_d = wait_cnt_q;
        else                      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB;
            rr_last_q   <= OWN_DBG;
            wait_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= OWN_EX;
            ex_rdata_q  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (ex_gnt)       rr_last_q <= OWN_EX;
            else if (dbg_gnt) rr_last_q <= OWN_DBG;
            rd_pend_q <= mem_en & ~mem_we;
            if (mem_en && !mem_we) rd_owner_q <= dbg_gnt ? OWN_DBG : OWN_EX;
            if (ex_rvalid)  ex_rdata_q  <= mem_rdata;
            if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration, memory contents and read return.
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_req, ex_we, dbg_req, dbg_we, dbg_lock;
    logic [7:0]  ex_addr, dbg_addr, mem_addr;
    logic [15:0] ex_wdata, dbg_wdata, mem_wdata, mem_rdata;
    logic        ex_gnt, ex_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, stall;
    logic [15:0] ex_rdata, dbg_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_gnt(ex_gnt), .ex_rvalid(ex_rvalid), .ex_rdata(ex_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT, and an independent copy owned by the model.
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Transaction-level model state.
    bit          m_last_dbg;
    bit          m_lock;
    int          m_wait;
    bit          m_pend, m_owner_dbg;
    logic [15:0] m_pdata, m_ex_hold, m_dbg_hold;

    task automatic model_reset();
        m_last_dbg = 1'b1; m_lock = 1'b0; m_wait = 0;
        m_pend = 1'b0; m_owner_dbg = 1'b0; m_pdata = '0;
        m_ex_hold = '0; m_dbg_hold = '0;
    endtask

    // {ex wins, dbg wins} for the current request inputs.
    function automatic logic [1:0] model_gnt();
        if (ex_req && m_wait == MAX_WAIT) return 2'b10;
        if (m_lock)                       return {1'b0, dbg_req};
        if (ex_req && dbg_req)            return m_last_dbg ? 2'b10 : 2'b01;
        return {ex_req, dbg_req};
    endfunction

    task automatic model_update();
        logic [1:0]  g;
        logic        w;
        logic [7:0]  a;
        logic [15:0] d;
        g = model_gnt();
        if (m_pend && !m_owner_dbg) m_ex_hold  = m_pdata;
        if (m_pend &&  m_owner_dbg) m_dbg_hold = m_pdata;
        m_pend = 1'b0;
        if (g != 2'b00) begin
            w = g[1] ? ex_we    : dbg_we;
            a = g[1] ? ex_addr  : dbg_addr;
            d = g[1] ? ex_wdata : dbg_wdata;
            if (w) ref_mem[a] = d;
            else begin
                m_pend = 1'b1; m_owner_dbg = g[0]; m_pdata = ref_mem[a];
            end
            m_last_dbg = g[0];
        end
        if (!m_lock) m_lock = g[0] && dbg_lock;
        else         m_lock = dbg_lock;
        if (ex_req && !g[1]) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
        else                 m_wait = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        ex_req = 0; ex_we = 0; ex_addr = '0; ex_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({ex_gnt, dbg_gnt, stall, mem_en, mem_we, mem_addr, mem_wdata,
             ex_rvalid, dbg_rvalid, ex_rdata, dbg_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b/%b stall=%b en=%b rv=%b/%b rd=%h/%h want all 0",
                     ex_gnt, dbg_gnt, stall, mem_en, ex_rvalid, dbg_rvalid, ex_rdata, dbg_rdata);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                ex_req = 1; ex_we = 0; ex_addr = 8'h01;
                dbg_req = 1; dbg_we = 0; dbg_addr = 8'h02;
            end else idle();
            #1;
            if (k < 4) begin
                n_checks++;
                if (ex_gnt !== (k % 2 == 0) || dbg_gnt !== (k % 2 == 1) || stall !== (k % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL simul_gnt[%0d]: got ex=%b dbg=%b stall=%b want ex=%b dbg=%b stall=%b",
                             k, ex_gnt, dbg_gnt, stall, k % 2 == 0, k % 2 == 1, k % 2 == 1);
                end
            end
            if (k >= 1) begin
                n_checks++;
                if (ex_rvalid !== ((k - 1) % 2 == 0) || dbg_rvalid !== ((k - 1) % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL simul_rvalid[%0d]: got ex=%b dbg=%b", k, ex_rvalid, dbg_rvalid);
                end
                n_checks++;
                if (((k - 1) % 2 == 0) ? (ex_rdata !== ref_mem[1]) : (dbg_rdata !== ref_mem[2])) begin
                    n_fail++;
                    $display("FAIL simul_rdata[%0d]: got ex=%h dbg=%h want ex=%h dbg=%h",
                             k, ex_rdata, dbg_rdata, ref_mem[1], ref_mem[2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_ex_read();
        ex_req = 1; ex_we = 0; ex_addr = 8'h10;
        #1;
        n_checks++;
        if (ex_gnt !== 1'b1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL ex_read_gnt: got gnt=%b stall=%b want 1/0", ex_gnt, stall);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (ex_rvalid !== 1'b1 || ex_rdata !== 16'hBEEF || dbg_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ex_read_data: got rv=%b rd=%h dbg_rv=%b want 1 beef 0", ex_rvalid, ex_rdata, dbg_rvalid);
        end
        tick();
    endtask

    task automatic test_lock();
        for (int k = 0; k < 6; k++) begin
            ex_req = 1; ex_we = 0; ex_addr = 8'h20;
            dbg_req = 1; dbg_we = 0; dbg_addr = 8'h21; dbg_lock = 1;
            #1;
            n_checks++;
            if (ex_gnt !== (k == 4) || dbg_gnt !== (k != 4) || stall !== (k != 4)) begin
                n_fail++;
                $display("FAIL lock_gnt[%0d]: got ex=%b dbg=%b stall=%b want ex=%b dbg=%b stall=%b",
                         k, ex_gnt, dbg_gnt, stall, k == 4, k != 4, k != 4);
            end
            if (k == 5) begin
                n_checks++;
                if (ex_rvalid !== 1'b1 || ex_rdata !== ref_mem[8'h20]) begin
                    n_fail++;
                    $display("FAIL lock_forced_read: got rv=%b rd=%h want 1 %h", ex_rvalid, ex_rdata, ref_mem[8'h20]);
                end
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_write_then_read();
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'hFF; dbg_wdata = 16'h1234;
        #1;
        n_checks++;
        if (dbg_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'hFF || mem_wdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_mux: got gnt=%b en=%b we=%b a=%h d=%h want 1 1 1 ff 1234",
                     dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        idle();
        ex_req = 1; ex_we = 0; ex_addr = 8'hFF;
        #1;
        n_checks++;
        if (ex_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || ex_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_no_rvalid: got rv=%b/%b gnt=%b want 0/0 1", ex_rvalid, dbg_rvalid, ex_gnt);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (ex_rvalid !== 1'b1 || ex_rdata !== 16'h1234) begin
            n_fail++; $display("FAIL wr_readback: got rv=%b rd=%h want 1 1234", ex_rvalid, ex_rdata);
        end
        tick();
    endtask

    task automatic test_withdraw();
        dbg_req = 1; dbg_addr = 8'h03;
        tick();
        idle();
        ex_req = 1; ex_addr = 8'h04; dbg_req = 1; dbg_addr = 8'h05;
        #1;
        n_checks++;
        if (dbg_gnt !== 1'b0 || ex_gnt !== 1'b1 || mem_addr !== 8'h04) begin
            n_fail++;
            $display("FAIL withdraw_tie: got ex=%b dbg=%b a=%h want 1 0 04", ex_gnt, dbg_gnt, mem_addr);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (dbg_rvalid !== 1'b0 || ex_rvalid !== 1'b1 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_drop: got dbg_rv=%b ex_rv=%b en=%b want 0 1 0", dbg_rvalid, ex_rvalid, mem_en);
        end
        tick();
        n_checks++;
        #1;
        if (dbg_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++; $display("FAIL withdraw_after: got dbg_rv=%b en=%b want 0 0", dbg_rvalid, mem_en);
        end
    endtask

    task automatic test_random();
        logic [1:0]  g;
        logic        rv_ex, rv_dbg;
        logic [15:0] exp_exd, exp_dbgd;
        for (int c = 0; c < 400; c++) begin
            ex_req    = ($urandom_range(0, 3) != 0);
            ex_we     = ($urandom_range(0, 2) == 0);
            ex_addr   = 8'($urandom_range(0, 31));
            ex_wdata  = 16'($urandom);
            dbg_req   = ($urandom_range(0, 2) != 0);
            dbg_we    = ($urandom_range(0, 2) == 0);
            dbg_addr  = 8'($urandom_range(0, 31));
            dbg_wdata = 16'($urandom);
            dbg_lock  = ($urandom_range(0, 4) == 0) || (m_lock && $urandom_range(0, 3) != 0);
            #1;
            g        = model_gnt();
            rv_ex    = m_pend && !m_owner_dbg;
            rv_dbg   = m_pend && m_owner_dbg;
            exp_exd  = rv_ex  ? m_pdata : m_ex_hold;
            exp_dbgd = rv_dbg ? m_pdata : m_dbg_hold;
            n_checks++;
            if ({ex_gnt, dbg_gnt} !== g || stall !== (ex_req && !g[1])) begin
                n_fail++;
                $display("FAIL rand_gnt[%0d]: got ex=%b dbg=%b stall=%b want ex=%b dbg=%b",
                         c, ex_gnt, dbg_gnt, stall, g[1], g[0]);
            end
            n_checks++;
            if (mem_en !== (g != 2'b00) ||
                (g[1] && {mem_we, mem_addr, mem_wdata} !== {ex_we, ex_addr, ex_wdata}) ||
                (g[0] && {mem_we, mem_addr, mem_wdata} !== {dbg_we, dbg_addr, dbg_wdata}) ||
                (g == 2'b00 && {mem_we, mem_addr, mem_wdata} !== '0)) begin
                n_fail++;
                $display("FAIL rand_mux[%0d]: got en=%b we=%b a=%h d=%h", c, mem_en, mem_we, mem_addr, mem_wdata);
            end
            n_checks++;
            if (ex_rvalid !== rv_ex || dbg_rvalid !== rv_dbg || ex_rdata !== exp_exd || dbg_rdata !== exp_dbgd) begin
                n_fail++;
                $display("FAIL rand_ret[%0d]: got rv=%b/%b rd=%h/%h want rv=%b/%b rd=%h/%h",
                         c, ex_rvalid, dbg_rvalid, ex_rdata, dbg_rdata, rv_ex, rv_dbg, exp_exd, exp_dbgd);
            end
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_read();
        ex_req = 1; ex_we = 0; ex_addr = 8'h07;
        tick();
        ex_addr = 8'h10;
        #1;
        n_checks++;
        if (ex_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rmid_gnt: got %b want 1", ex_gnt);
        end
        #1;
        rst = 0;
        idle();
        #1;
        n_checks++;
        if ({ex_gnt, dbg_gnt, stall, mem_en, ex_rvalid, dbg_rvalid, ex_rdata, dbg_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rmid_during: got rv=%b/%b rd=%h/%h en=%b want all 0",
                     ex_rvalid, dbg_rvalid, ex_rdata, dbg_rdata, mem_en);
        end
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1;
        #1;
        n_checks++;
        if (ex_rvalid !== 1'b0 || ex_rdata !== 16'h0000) begin
            n_fail++; $display("FAIL rmid_release: got rv=%b rd=%h want 0 0000", ex_rvalid, ex_rdata);
        end
        tick();
        ex_req = 1; ex_addr = 8'h05; dbg_req = 1; dbg_addr = 8'h06;
        #1;
        n_checks++;
        if (ex_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rmid_tie: got ex=%b dbg=%b want 1 0", ex_gnt, dbg_gnt);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (ex_rvalid !== 1'b1 || ex_rdata !== ref_mem[5]) begin
            n_fail++; $display("FAIL rmid_tie_data: got rv=%b rd=%h want 1 %h", ex_rvalid, ex_rdata, ref_mem[5]);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 37 + 5);
            ref_mem[i] = 16'(i * 37 + 5);
        end
        mem[8'h10]     = 16'hBEEF;
        ref_mem[8'h10] = 16'hBEEF;
        rst = 0;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1;
        @(negedge clk);
        test_simultaneous();
        test_ex_read();
        test_lock();
        test_write_then_read();
        test_withdraw();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
